// File: rtl/instruction_monitor_mp_pkg.sv
// Shared definitions for the multi-slot instruction monitor: FSM encoding, table geometry and
// slot popcount.
package instruction_monitor_mp_pkg;

   localparam int unsigned TableSize        = 256;
   localparam logic [7:0]  ExtPrefixDefault = 8'hff;
   localparam int unsigned MaxSlots         = 4;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StDrain = 2'd1,
      StDone  = 2'd2
   } mon_state_e;

   function automatic logic [2:0] popcount(input logic [MaxSlots-1:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < MaxSlots; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/instruction_monitor_mp_table.sv
// 256-entry opcode enable bitmap: one write port, NumSlots combinational read ports that see
// the pre-edge contents.
module instruction_monitor_mp_table
   import instruction_monitor_mp_pkg::*;
#(
   parameter int unsigned NumSlots    = 2,
   parameter bit          ResetEnable = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_en_i,
   input  logic [7:0]            wr_idx_i,
   input  logic                  wr_data_i,
   input  logic [8*NumSlots-1:0] rd_idx_i,
   output logic [NumSlots-1:0]   rd_data_o
);

   logic [TableSize-1:0] tbl_q, tbl_d;

   always_comb begin
      tbl_d = tbl_q;
      if (wr_en_i) begin
         tbl_d[wr_idx_i] = wr_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tbl_q <= {TableSize{ResetEnable}};
      end else begin
         tbl_q <= tbl_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      for (int s = 0; s < NumSlots; s++) begin
         rd_data_o[s] = tbl_q[rd_idx_i[8*s +: 8]];
      end
   end

endmodule

// File: rtl/instruction_monitor_mp.sv
// Checks up to NUM_SLOTS issued opcodes per cycle against base/extended enable tables, counts
// and captures violations, and raises a sticky endsim after a threshold plus drain delay.
module instruction_monitor_mp
   import instruction_monitor_mp_pkg::*;
#(
   parameter int unsigned NUM_SLOTS    = 2,
   parameter logic [7:0]  EXT_PREFIX   = ExtPrefixDefault,
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned MAX_ERRORS   = 1,
   parameter int unsigned ABORT_DELAY  = 4,
   parameter bit          RESET_ENABLE = 1'b1,
   localparam int unsigned SlotW       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SLOTS-1:0]   valid_op,
   input  logic [8*NUM_SLOTS-1:0] opcode_1,
   input  logic [8*NUM_SLOTS-1:0] opcode_2,
   input  logic                   tbl_wr_en,
   input  logic                   tbl_wr_ext,
   input  logic [7:0]             tbl_wr_idx,
   input  logic                   tbl_wr_data,
   input  logic                   clear_counts,
   output logic [CNT_W-1:0]       instr_count,
   output logic [CNT_W-1:0]       err_count,
   output logic                   err_valid,
   output logic [SlotW-1:0]       err_slot,
   output logic [15:0]            err_opcode,
   output logic [15:0]            first_opcode,
   output logic                   endsim
);

   localparam int unsigned DlyW = (ABORT_DELAY > 1) ? $clog2(ABORT_DELAY) : 1;
   localparam logic [DlyW-1:0] DlyInit = DlyW'((ABORT_DELAY > 0) ? ABORT_DELAY - 1 : 0);
   localparam logic [CNT_W+31:0] MaxErrW = (CNT_W + 32)'(MAX_ERRORS);

   logic [NUM_SLOTS-1:0] base_rd, ext_rd, viol;
   logic [SlotW-1:0]     hit_slot;
   logic [15:0]          hit_op;
   logic                 any_viol, thresh_hit;

   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic             err_valid_q, err_valid_d;
   logic [SlotW-1:0] err_slot_q, err_slot_d;
   logic [15:0]      err_opcode_q, err_opcode_d;
   logic [15:0]      first_opcode_q, first_opcode_d;
   logic             first_seen_q, first_seen_d;
   logic             endsim_q, endsim_d;
   logic [DlyW-1:0]  dly_q, dly_d;
   mon_state_e       state_q, state_d;

   instruction_monitor_mp_table #(
      .NumSlots    (NUM_SLOTS),
      .ResetEnable (RESET_ENABLE)
   ) u_base_tbl (
      .clk_i     (clk),
      .rst_i     (reset),
      .wr_en_i   (tbl_wr_en & ~tbl_wr_ext),
      .wr_idx_i  (tbl_wr_idx),
      .wr_data_i (tbl_wr_data),
      .rd_idx_i  (opcode_1),
      .rd_data_o (base_rd)
   );

   instruction_monitor_mp_table #(
      .NumSlots    (NUM_SLOTS),
      .ResetEnable (RESET_ENABLE)
   ) u_ext_tbl (
      .clk_i     (clk),
      .rst_i     (reset),
      .wr_en_i   (tbl_wr_en & tbl_wr_ext),
      .wr_idx_i  (tbl_wr_idx),
      .wr_data_i (tbl_wr_data),
      .rd_idx_i  (opcode_2),
      .rd_data_o (ext_rd)
   );

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] inc);
      logic [CNT_W+2:0] sum;
      sum = {3'b000, a} + (CNT_W + 3)'(inc);
      return (sum[CNT_W+2:CNT_W] != 3'b000) ? '1 : sum[CNT_W-1:0];
   endfunction

   // Invalid slots are masked by the AND, so X opcodes on them never raise a violation.
   always_comb begin
      viol = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (opcode_1[8*s +: 8] == EXT_PREFIX) begin
            viol[s] = valid_op[s] & ~ext_rd[s];
         end else begin
            viol[s] = valid_op[s] & ~base_rd[s];
         end
      end
   end

   // Descending scan so the lowest violating slot is the last one written.
   always_comb begin
      hit_slot = '0;
      hit_op   = '0;
      for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
         if (viol[s]) begin
            hit_slot = SlotW'(s);
            if (opcode_1[8*s +: 8] == EXT_PREFIX) begin
               hit_op = {opcode_1[8*s +: 8], opcode_2[8*s +: 8]};
            end else begin
               hit_op = {opcode_1[8*s +: 8], 8'h00};
            end
         end
      end
   end

   assign any_viol = |viol;

   always_comb begin
      instr_count_d  = sat_add(instr_count_q, popcount(MaxSlots'(valid_op)));
      err_count_d    = sat_add(err_count_q, popcount(MaxSlots'(viol)));
      if (clear_counts) begin
         instr_count_d = '0;
         err_count_d   = '0;
      end
      err_valid_d    = any_viol;
      err_slot_d     = err_slot_q;
      err_opcode_d   = err_opcode_q;
      first_opcode_d = first_opcode_q;
      first_seen_d   = first_seen_q;
      if (any_viol) begin
         err_slot_d   = hit_slot;
         err_opcode_d = hit_op;
         if (!first_seen_q) begin
            first_opcode_d = hit_op;
            first_seen_d   = 1'b1;
         end
      end
   end

   assign thresh_hit = {32'b0, err_count_d} >= MaxErrW;

   always_comb begin
      state_d  = state_q;
      dly_d    = dly_q;
      endsim_d = endsim_q;
      case (state_q)
         StRun: begin
            if (thresh_hit) begin
               if (ABORT_DELAY == 0) begin
                  state_d  = StDone;
                  endsim_d = 1'b1;
               end else begin
                  state_d = StDrain;
                  dly_d   = DlyInit;
               end
            end
         end
         StDrain: begin
            if (dly_q == '0) begin
               state_d  = StDone;
               endsim_d = 1'b1;
            end else begin
               dly_d = dly_q - 1'b1;
            end
         end
         StDone: begin
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_count_q  <= '0;
         err_count_q    <= '0;
         err_valid_q    <= 1'b0;
         err_slot_q     <= '0;
         err_opcode_q   <= '0;
         first_opcode_q <= '0;
         first_seen_q   <= 1'b0;
         endsim_q       <= 1'b0;
         dly_q          <= '0;
         state_q        <= StRun;
      end else begin
         instr_count_q  <= instr_count_d;
         err_count_q    <= err_count_d;
         err_valid_q    <= err_valid_d;
         err_slot_q     <= err_slot_d;
         err_opcode_q   <= err_opcode_d;
         first_opcode_q <= first_opcode_d;
         first_seen_q   <= first_seen_d;
         endsim_q       <= endsim_d;
         dly_q          <= dly_d;
         state_q        <= state_d;
      end
   end

   assign instr_count  = instr_count_q;
   assign err_count    = err_count_q;
   assign err_valid    = err_valid_q;
   assign err_slot     = err_slot_q;
   assign err_opcode   = err_opcode_q;
   assign first_opcode = first_opcode_q;
   assign endsim       = endsim_q;

endmodule

// File: tb/tb_instruction_monitor_mp.sv
// Bench for instruction_monitor_mp: three parameterisations share one stimulus stream and are
// checked every cycle against a behavioural model, plus directed scenario checks.
module tb_instruction_monitor_mp;

   localparam longint unsigned CMAX [3] = '{64'hFFFF_FFFF, 64'd15, 64'd255};
   localparam int unsigned     MAXE [3] = '{1, 2, 3};
   localparam int unsigned     DLY  [3] = '{4, 1, 0};

   logic        clk, reset;
   logic [1:0]  valid;
   logic [15:0] op1, op2;
   logic        wr_en, wr_ext, wr_data, clr;
   logic [7:0]  wr_idx;

   logic [31:0] a_icnt, a_ecnt;
   logic [3:0]  b_icnt, b_ecnt;
   logic [7:0]  c_icnt, c_ecnt;
   logic        a_ev, b_ev, c_ev, a_slot, b_slot, c_slot, a_end, b_end, c_end;
   logic [15:0] a_eop, b_eop, c_eop, a_first, b_first, c_first;

   logic [63:0] g_icnt [3], g_ecnt [3], g_ev [3], g_slot [3], g_eop [3], g_first [3], g_end [3];

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit              base_t [256];
   bit              ext_t  [256];
   longint unsigned m_icnt [3], m_ecnt [3];
   bit              m_ev [3], m_seen [3], m_end [3], m_trig [3];
   int              m_slot [3], m_rem [3];
   logic [15:0]     m_eop [3], m_first [3];

   instruction_monitor_mp dut_a (
      .clk(clk), .reset(reset), .valid_op(valid), .opcode_1(op1), .opcode_2(op2),
      .tbl_wr_en(wr_en), .tbl_wr_ext(wr_ext), .tbl_wr_idx(wr_idx), .tbl_wr_data(wr_data),
      .clear_counts(clr), .instr_count(a_icnt), .err_count(a_ecnt), .err_valid(a_ev),
      .err_slot(a_slot), .err_opcode(a_eop), .first_opcode(a_first), .endsim(a_end)
   );

   instruction_monitor_mp #(.CNT_W(4), .MAX_ERRORS(2), .ABORT_DELAY(1)) dut_b (
      .clk(clk), .reset(reset), .valid_op(valid), .opcode_1(op1), .opcode_2(op2),
      .tbl_wr_en(wr_en), .tbl_wr_ext(wr_ext), .tbl_wr_idx(wr_idx), .tbl_wr_data(wr_data),
      .clear_counts(clr), .instr_count(b_icnt), .err_count(b_ecnt), .err_valid(b_ev),
      .err_slot(b_slot), .err_opcode(b_eop), .first_opcode(b_first), .endsim(b_end)
   );

   instruction_monitor_mp #(.CNT_W(8), .MAX_ERRORS(3), .ABORT_DELAY(0)) dut_c (
      .clk(clk), .reset(reset), .valid_op(valid), .opcode_1(op1), .opcode_2(op2),
      .tbl_wr_en(wr_en), .tbl_wr_ext(wr_ext), .tbl_wr_idx(wr_idx), .tbl_wr_data(wr_data),
      .clear_counts(clr), .instr_count(c_icnt), .err_count(c_ecnt), .err_valid(c_ev),
      .err_slot(c_slot), .err_opcode(c_eop), .first_opcode(c_first), .endsim(c_end)
   );

   assign g_icnt[0] = 64'(a_icnt);  assign g_icnt[1] = 64'(b_icnt);  assign g_icnt[2] = 64'(c_icnt);
   assign g_ecnt[0] = 64'(a_ecnt);  assign g_ecnt[1] = 64'(b_ecnt);  assign g_ecnt[2] = 64'(c_ecnt);
   assign g_ev[0]   = 64'(a_ev);    assign g_ev[1]   = 64'(b_ev);    assign g_ev[2]   = 64'(c_ev);
   assign g_slot[0] = 64'(a_slot);  assign g_slot[1] = 64'(b_slot);  assign g_slot[2] = 64'(c_slot);
   assign g_eop[0]  = 64'(a_eop);   assign g_eop[1]  = 64'(b_eop);   assign g_eop[2]  = 64'(c_eop);
   assign g_first[0] = 64'(a_first); assign g_first[1] = 64'(b_first);
   assign g_first[2] = 64'(c_first);
   assign g_end[0]  = 64'(a_end);   assign g_end[1]  = 64'(b_end);   assign g_end[2]  = 64'(c_end);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) begin
         base_t[i] = 1'b1;
         ext_t[i]  = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
         m_icnt[k] = 0;  m_ecnt[k] = 0;  m_ev[k] = 0;  m_seen[k] = 0;  m_end[k] = 0;
         m_trig[k] = 0;  m_slot[k] = 0;  m_rem[k] = 0; m_eop[k] = '0; m_first[k] = '0;
      end
   endtask

   // Advances the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      int nv, ne, low;
      logic [15:0] lowop;
      logic [7:0]  b1, b2;
      bit v;
      nv = 0; ne = 0; low = -1; lowop = '0;
      for (int s = 0; s < 2; s++) begin
         if (valid[s]) begin
            nv++;
            b1 = op1[8*s +: 8];
            b2 = op2[8*s +: 8];
            v  = (b1 == 8'hff) ? !ext_t[b2] : !base_t[b1];
            if (v) begin
               ne++;
               if (low < 0) begin
                  low   = s;
                  lowop = (b1 == 8'hff) ? {b1, b2} : {b1, 8'h00};
               end
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         if (clr) begin
            m_icnt[k] = 0;
            m_ecnt[k] = 0;
         end else begin
            m_icnt[k] = (m_icnt[k] + nv > CMAX[k]) ? CMAX[k] : m_icnt[k] + nv;
            m_ecnt[k] = (m_ecnt[k] + ne > CMAX[k]) ? CMAX[k] : m_ecnt[k] + ne;
         end
         m_ev[k] = (ne > 0);
         if (ne > 0) begin
            m_slot[k] = low;
            m_eop[k]  = lowop;
            if (!m_seen[k]) begin
               m_seen[k]  = 1'b1;
               m_first[k] = lowop;
            end
         end
         if (m_trig[k]) begin
            if (m_rem[k] > 0) begin
               m_rem[k]--;
               if (m_rem[k] == 0) m_end[k] = 1'b1;
            end
         end else if (m_ecnt[k] >= MAXE[k]) begin
            m_trig[k] = 1'b1;
            m_rem[k]  = DLY[k];
            if (m_rem[k] == 0) m_end[k] = 1'b1;
         end
      end
      if (wr_en) begin
         if (wr_ext) ext_t[wr_idx] = wr_data;
         else        base_t[wr_idx] = wr_data;
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 3; k++) begin
         check_val($sformatf("instr_count[%0d]", k), g_icnt[k], 64'(m_icnt[k]));
         check_val($sformatf("err_count[%0d]", k), g_ecnt[k], 64'(m_ecnt[k]));
         check_val($sformatf("err_valid[%0d]", k), g_ev[k], 64'(m_ev[k]));
         check_val($sformatf("err_slot[%0d]", k), g_slot[k], 64'(m_slot[k]));
         check_val($sformatf("err_opcode[%0d]", k), g_eop[k], 64'(m_eop[k]));
         check_val($sformatf("first_opcode[%0d]", k), g_first[k], 64'(m_first[k]));
         check_val($sformatf("endsim[%0d]", k), g_end[k], 64'(m_end[k]));
      end
   endtask

   task automatic idle();
      valid = 2'b00; op1 = '0; op2 = '0; wr_en = 0; wr_ext = 0; wr_idx = '0; wr_data = 0; clr = 0;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
      idle();
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      model_reset();
      #1;
      compare_all();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      compare_all();
   endtask

   task automatic tbl_write(input bit ext, input logic [7:0] idx, input bit data);
      wr_en = 1; wr_ext = ext; wr_idx = idx; wr_data = data;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      do_reset();

      // Legal traffic only: every table bit is enabled after reset.
      for (int i = 0; i < 100; i++) begin
         valid = 2'b11;
         op1 = 16'($urandom);
         op2 = 16'($urandom);
         step();
      end
      check_val("legal_instr_count", g_icnt[0], 64'd200);
      check_val("legal_err_count", g_ecnt[0], 64'd0);
      check_val("legal_endsim", g_end[0], 64'd0);

      // Two extended violations on one edge.
      tbl_write(1, 8'h12, 0);
      step();
      valid = 2'b11; op1 = 16'hffff; op2 = 16'h1212;
      step();
      check_val("ext_err_count_b", g_ecnt[1], 64'd2);
      check_val("ext_err_slot_b", g_slot[1], 64'd0);
      check_val("ext_err_opcode_b", g_eop[1], 64'hff12);
      check_val("ext_endsim_b_entry", g_end[1], 64'd0);
      step();
      check_val("ext_endsim_b_drain", g_end[1], 64'd1);
      tbl_write(1, 8'h12, 1);
      step();
      valid = 2'b11; op1 = 16'hffff; op2 = 16'h1212;
      step();
      check_val("ext_reenabled", g_ev[1], 64'd0);

      // Write and use on the same edge sees the old table bit.
      tbl_write(0, 8'h10, 0);
      valid = 2'b01; op1 = 16'h0010;
      step();
      check_val("same_edge_write", g_ev[0], 64'd0);
      valid = 2'b01; op1 = 16'h0010;
      step();
      check_val("next_edge_use", g_ev[0], 64'd1);
      check_val("threshold_c_same_edge", g_end[2], 64'd1);

      // Base violation on slot 1; endsim follows exactly four cycles later.
      do_reset();
      tbl_write(0, 8'h5a, 0);
      step();
      valid = 2'b11; op1 = 16'h5a01;
      step();
      check_val("base_err_valid", g_ev[0], 64'd1);
      check_val("base_err_slot", g_slot[0], 64'd1);
      check_val("base_err_opcode", g_eop[0], 64'h5a00);
      check_val("base_first_opcode", g_first[0], 64'h5a00);
      for (int i = 1; i <= 4; i++) begin
         step();
         check_val($sformatf("drain_endsim_%0d", i), g_end[0], (i == 4) ? 64'd1 : 64'd0);
      end
      check_val("err_valid_pulse", g_ev[0], 64'd0);
      check_val("err_opcode_hold", g_eop[0], 64'h5a00);

      // Reset in the middle of the drain aborts the sequence and reloads the tables.
      do_reset();
      tbl_write(0, 8'h33, 0);
      step();
      valid = 2'b01; op1 = 16'h0033;
      step();
      step();
      step();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step();
      end
      check_val("aborted_endsim", g_end[0], 64'd0);
      valid = 2'b01; op1 = 16'h0033;
      step();
      check_val("reloaded_table", g_ev[0], 64'd0);

      // Saturation of the narrow counter, then clear against a concurrent violation.
      do_reset();
      tbl_write(0, 8'h77, 0);
      step();
      for (int i = 0; i < 10; i++) begin
         valid = 2'b11; op1 = 16'h7777;
         step();
      end
      check_val("sat_err_count_b", g_ecnt[1], 64'd15);
      check_val("sat_err_count_a", g_ecnt[0], 64'd20);
      valid = 2'b11; op1 = 16'h7777; clr = 1;
      step();
      check_val("clear_err_count_b", g_ecnt[1], 64'd0);
      check_val("clear_instr_count_a", g_icnt[0], 64'd0);
      check_val("clear_keeps_endsim", g_end[0], 64'd1);

      // Invalid slots carrying X opcodes are ignored.
      valid = 2'b00; op1 = 'x; op2 = 'x;
      step();
      check_val("x_ignored", g_ev[0], 64'd0);

      // Randomized traffic over a small opcode space so table writes collide with issues.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         valid = 2'($urandom_range(0, 3));
         for (int s = 0; s < 2; s++) begin
            op1[8*s +: 8] = ($urandom_range(0, 3) == 0) ? 8'hff : 8'($urandom_range(0, 7));
            op2[8*s +: 8] = 8'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 7) == 0) begin
            op1[15:8] = 'x;
            valid[1]  = 1'b0;
         end
         if ($urandom_range(0, 2) == 0) begin
            tbl_write(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                      ($urandom_range(0, 2) != 0));
         end
         clr = ($urandom_range(0, 15) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
